// File: rtl/window_comparator.sv
// Registered window comparator: single-shot EQ/GT/LT/MAX/MIN with one-cycle
// latency, plus windowed MAX/MIN/match-count over DEPTH valid samples.
module window_comparator #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [2:0]           operation,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   result,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int unsigned ResW = 2 * WIDTH;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [2:0] OpEq     = 3'd0;
    localparam logic [2:0] OpGt     = 3'd1;
    localparam logic [2:0] OpLt     = 3'd2;
    localparam logic [2:0] OpMax    = 3'd3;
    localparam logic [2:0] OpMin    = 3'd4;
    localparam logic [2:0] OpWMax   = 3'd5;
    localparam logic [2:0] OpWMin   = 3'd6;
    localparam logic [2:0] OpWEqCnt = 3'd7;

    typedef enum logic [1:0] {StIdle, StAccum, StDone} stateT;

    stateT            stateQ;
    logic [2:0]       opQ;
    logic [ResW-1:0]  accQ;
    logic [CntW-1:0]  cntQ;

    logic [ResW-1:0]  startAcc;
    logic [ResW-1:0]  nextAcc;
    logic             lastSample;

    // Value results carry ones in the upper half to blank the high display digit.
    function automatic logic [ResW-1:0] packValue(input logic [WIDTH-1:0] v);
        return {{WIDTH{1'b1}}, v};
    endfunction

    function automatic logic [ResW-1:0] singleShot(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (op)
            OpEq:    return {{(ResW-1){1'b0}}, a == b};
            OpGt:    return {{(ResW-1){1'b0}}, a > b};
            OpLt:    return {{(ResW-1){1'b0}}, a < b};
            OpMax:   return packValue((a > b) ? a : b);
            OpMin:   return packValue((a < b) ? a : b);
            default: return '0;
        endcase
    endfunction

    function automatic logic [ResW-1:0] accInit(input logic [2:0] op);
        return (op == OpWMin) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : '0;
    endfunction

    function automatic logic [ResW-1:0] accStep(input logic [2:0] op,
                                                input logic [ResW-1:0] acc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            OpWMax:   return {{WIDTH{1'b0}}, (a > acc[WIDTH-1:0]) ? a : acc[WIDTH-1:0]};
            OpWMin:   return {{WIDTH{1'b0}}, (a < acc[WIDTH-1:0]) ? a : acc[WIDTH-1:0]};
            OpWEqCnt: return acc + ResW'(a == b);
            default:  return acc;
        endcase
    endfunction

    function automatic logic [ResW-1:0] packWindow(input logic [2:0] op,
                                                   input logic [ResW-1:0] acc);
        return (op == OpWEqCnt) ? acc : packValue(acc[WIDTH-1:0]);
    endfunction

    // Accumulator candidates: first sample taken with start, and a sample while accumulating.
    always_comb begin
        startAcc   = accStep(operation, accInit(operation), x, y);
        nextAcc    = accStep(opQ, accQ, x, y);
        lastSample = (cntQ == CntW'(DEPTH - 1));
    end

    // Control FSM with registered result/out_valid/busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= StIdle;
            opQ       <= OpEq;
            accQ      <= '0;
            cntQ      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    if (in_valid && operation <= OpMin) begin
                        // Single-shot has priority; start is ignored for ops 0-4.
                        result    <= singleShot(operation, x, y);
                        out_valid <= 1'b1;
                    end else if (start && operation >= OpWMax) begin
                        opQ  <= operation;
                        busy <= 1'b1;
                        if (in_valid) begin
                            accQ <= startAcc;
                            cntQ <= CntW'(1);
                            if (DEPTH == 1) begin
                                stateQ    <= StDone;
                                result    <= packWindow(operation, startAcc);
                                out_valid <= 1'b1;
                            end else begin
                                stateQ <= StAccum;
                            end
                        end else begin
                            accQ   <= accInit(operation);
                            cntQ   <= '0;
                            stateQ <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    // Stall on in_valid=0; no timeout.
                    if (in_valid) begin
                        accQ <= nextAcc;
                        cntQ <= cntQ + CntW'(1);
                        if (lastSample) begin
                            stateQ    <= StDone;
                            result    <= packWindow(opQ, nextAcc);
                            out_valid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Result was presented on entry; inputs this cycle are dropped.
                    stateQ <= StIdle;
                    busy   <= 1'b0;
                end
                default: begin
                    stateQ <= StIdle;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_comparator.sv
// Self-checking bench for window_comparator: directed scenarios plus random
// traffic checked cycle by cycle against a queue-based reference model.
module tb_window_comparator;

    localparam int W = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [2:0]     operation = 3'd0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic [2*W-1:0] result;
    logic           out_valid;
    logic           busy;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: 0 idle, 1 collecting, 2 presenting result.
    int             phase = 0;
    int             winOp = 0;
    int             xs[$];
    int             ys[$];
    logic [2*W-1:0] expRes = '0;
    logic           expOv = 1'b0;
    logic           expBusy = 1'b0;

    always #5 clk = ~clk;

    window_comparator #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .operation(operation),
        .x(x),
        .y(y),
        .result(result),
        .out_valid(out_valid),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int blankHigh(input int v);
        return (((1 << W) - 1) << W) + v;
    endfunction

    function automatic int modelSingle(input int op, input int a, input int b);
        case (op)
            0: return (a == b) ? 1 : 0;
            1: return (a > b) ? 1 : 0;
            2: return (a < b) ? 1 : 0;
            3: return blankHigh((a > b) ? a : b);
            default: return blankHigh((a < b) ? a : b);
        endcase
    endfunction

    function automatic int modelWindow();
        int r;
        if (winOp == 7) begin
            r = 0;
            foreach (xs[i]) if (xs[i] == ys[i]) r++;
            return r;
        end
        r = xs[0];
        foreach (xs[i]) begin
            if (winOp == 5 && xs[i] > r) r = xs[i];
            if (winOp == 6 && xs[i] < r) r = xs[i];
        end
        return blankHigh(r);
    endfunction

    task automatic takeSample();
        xs.push_back(int'(x));
        ys.push_back(int'(y));
        if (xs.size() == D) begin
            phase  = 2;
            expRes = (2*W)'(modelWindow());
            expOv  = 1'b1;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        expOv = 1'b0;
        if (phase == 2) begin
            phase = 0;
        end else if (phase == 1) begin
            if (in_valid) takeSample();
        end else if (in_valid && operation <= 3'd4) begin
            expRes = (2*W)'(modelSingle(int'(operation), int'(x), int'(y)));
            expOv  = 1'b1;
        end else if (start && operation >= 3'd5) begin
            winOp = int'(operation);
            xs.delete();
            ys.delete();
            phase = 1;
            if (in_valid) takeSample();
        end
        expBusy = (phase != 0);
    endtask

    task automatic cycle(input bit st, input bit iv, input int op, input int xv, input int yv);
        logic [31:0] ov32, xv32, yv32;
        ov32 = op;
        xv32 = xv;
        yv32 = yv;
        start     = st;
        in_valid  = iv;
        operation = ov32[2:0];
        x         = xv32[W-1:0];
        y         = yv32[W-1:0];
        @(posedge clk);
        modelStep();
        #1;
        check("out_valid", out_valid, expOv);
        check("busy", busy, expBusy);
        check("result", result, expRes);
    endtask

    // Assert reset between edges and check outputs clear before any clock edge.
    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        phase   = 0;
        expRes  = '0;
        expOv   = 1'b0;
        expBusy = 1'b0;
        check("rst_result", result, expRes);
        check("rst_out_valid", out_valid, expOv);
        check("rst_busy", busy, expBusy);
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        doReset();

        // Back-to-back single-shots.
        cycle(0, 1, 3, 5, 9);
        check("ss_max", result, 8'hF9);
        cycle(0, 1, 0, 7, 7);
        check("ss_eq_tie", result, 8'h01);
        cycle(0, 1, 1, 3, 3);
        check("ss_gt_tie", result, 8'h00);
        cycle(0, 0, 0, 0, 0);

        // WMAX with gaps.
        cycle(1, 0, 5, 0, 0);
        cycle(0, 1, 5, 2, 0);
        cycle(0, 0, 5, 0, 0);
        cycle(0, 1, 5, 14, 0);
        cycle(0, 1, 5, 7, 0);
        cycle(0, 0, 5, 0, 0);
        cycle(0, 1, 5, 1, 0);
        check("wmax", result, 8'hFE);
        cycle(0, 1, 0, 3, 3);   // dropped while presenting
        cycle(0, 0, 0, 0, 0);

        // WMIN with op=0/start presented while busy; sample taken with start.
        cycle(1, 1, 6, 9, 0);
        cycle(1, 1, 0, 3, 3);
        cycle(0, 1, 0, 15, 15);
        cycle(0, 1, 0, 3, 0);
        check("wmin", result, 8'hF3);
        cycle(0, 0, 0, 0, 0);

        // WEQCNT.
        cycle(1, 0, 7, 0, 0);
        cycle(0, 1, 7, 1, 1);
        cycle(0, 1, 7, 2, 3);
        cycle(0, 1, 7, 4, 4);
        cycle(0, 1, 7, 5, 5);
        check("weqcnt", result, 8'h03);
        cycle(0, 0, 0, 0, 0);

        // Window op without start is ignored; start with op 0-4 is a single-shot.
        cycle(0, 1, 5, 9, 0);
        cycle(1, 1, 2, 1, 8);
        check("start_ss_lt", result, 8'h01);

        // Abort mid-window.
        cycle(1, 1, 5, 3, 0);
        cycle(0, 1, 5, 8, 0);
        doReset();
        cycle(0, 1, 4, 6, 2);
        check("after_abort_min", result, 8'hF2);

        // Random traffic; small operand range makes ties and matches common.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3))
                                                  : int'($urandom_range(0, 15)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
